// File: rtl/wb_pkg.sv
// Shared types and default sizing for the write buffer.
package wb_pkg;
    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 32;
    localparam int DW_DEF    = 32;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        READ,
        RESP
    } state_e;
endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO holding buffered {addr, data} write entries.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [W-1:0]                 head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/write_buffer.sv
// Write-through buffer between cache and memory; reads wait for buffered writes to drain.
module write_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    input  logic          c_rd,
    input  logic          c_wr,
    output logic [DW-1:0] c_rdata,
    output logic          c_stall,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic          m_req,
    output logic          m_we,
    input  logic          m_ready,
    input  logic [DW-1:0] m_rdata
);
    localparam int CW = $clog2(DEPTH+1);

    state_e        state_q, state_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          wr_done_q, wr_done_d;
    logic          push, pop, full, empty;
    logic [CW-1:0] count;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    // A write paired with a stalled read is taken once; the cache keeps
    // c_wr high until the stall clears, so later cycles must not re-enqueue it.
    assign push      = c_wr && !full && !wr_done_q;
    assign c_stall   = (c_rd && (state_q != RESP)) || (c_wr && full && !wr_done_q);
    assign wr_done_d = c_stall ? (wr_done_q || push) : 1'b0;
    assign c_rdata   = rdata_q;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({c_addr, c_wdata}),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  ({head_addr, head_data})
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        pop     = 1'b0;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        case (state_q)
            IDLE: begin
                // An entry landing this edge starts draining right away.
                if (!empty || push) begin
                    state_d = DRAIN;
                end else if (c_rd) begin
                    state_d = READ;
                end
            end
            DRAIN: begin
                m_req   = 1'b1;
                m_we    = 1'b1;
                m_addr  = head_addr;
                m_wdata = head_data;
                if (m_ready) begin
                    pop = 1'b1;
                    if (count == CW'(1) && !push) begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                m_req  = 1'b1;
                m_addr = c_addr;
                if (m_ready) begin
                    rdata_d = m_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rdata_q   <= '0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            wr_done_q <= wr_done_d;
        end
    end
endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered write entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 32, meaning address width in bits.
REQ-003 SHALL have parameter DW, default 32, meaning data width in bits.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have these cache-side ports:
- c_addr  in  AW  cache request address.
- c_wdata  in  DW  cache write data.
- c_rd  in  1  cache read-miss request; held until c_stall low.
- c_wr  in  1  cache write-through request.
- c_rdata  out  DW  read response data.
- c_stall  out  1  request not complete this cycle; cache holds inputs.
REQ-006 SHALL have these memory-side ports:
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_req  out  1  memory request valid.
- m_we  out  1  request is a write (1) or read (0).
- m_ready  in  1  memory accepts the request / returns data this cycle.
- m_rdata  in  DW  read data, valid when m_req && !m_we && m_ready.

Function
REQ-007 SHALL hold write entries {addr, data} in a FIFO; count range 0..DEPTH, width $clog2(DEPTH+1).
REQ-008 SHALL enqueue a write at the edge when c_wr=1 and count<DEPTH at cycle start; c_stall=0 that cycle when c_rd=0.
REQ-009 SHALL assert c_stall combinationally when c_wr=1 and count==DEPTH; a dequeue in the same cycle does not admit the write (accepted next cycle at earliest).
REQ-010 SHALL implement FSM states IDLE, DRAIN, READ, RESP.
REQ-011 IDLE -> DRAIN when count>0; IDLE -> READ when count==0 and c_rd=1; otherwise stay IDLE.
REQ-012 DRAIN: m_req=1, m_we=1, m_addr/m_wdata = FIFO head, held stable until m_ready; on m_req&&m_ready pop head; leave for IDLE when the pop empties the FIFO, else stay DRAIN.
REQ-013 Reads SHALL NOT overtake buffered writes: c_rd with count>0 waits (c_stall=1) until the FIFO fully drains.
REQ-014 READ: m_req=1, m_we=0, m_addr=c_addr; on m_ready capture m_rdata into c_rdata register, go RESP.
REQ-015 RESP: c_stall=0 for exactly one cycle with c_rdata valid; return to IDLE next cycle.
REQ-016 Minimum read latency with empty FIFO and m_ready=1 immediately: c_rd seen cycle 0, m_req cycle 1, c_stall low cycle 2.
REQ-017 c_stall SHALL be 1 whenever c_rd=1 and state!=RESP, or as in REQ-009; else 0.
REQ-018 Writes arriving during DRAIN/READ SHALL be enqueued per REQ-008 without disturbing the memory request in progress.
REQ-019 c_rd and c_wr together: write enqueued first per REQ-008; read then waits for drain including that entry.
REQ-020 m_req SHALL be 0 in IDLE and RESP; m_we=0 when m_req=0.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH; simultaneous enqueue and dequeue keeps count unchanged.

Reset
REQ-022 On reset: state=IDLE, count=0, pointers=0, c_rdata=0, c_stall=0, m_req=0, m_we=0, m_addr=0, m_wdata=0.
REQ-023 Reset mid-transaction SHALL abandon the in-flight memory request (m_req low the cycle after reset) and discard all buffered entries.

Structure
REQ-024 Package wb_pkg SHALL hold the FSM state enum and the default DEPTH/AW/DW constants.
REQ-025 FIFO storage and pointers SHALL be sub-module wb_fifo (push, pop, full, empty, count, head outputs); FSM stays in write_buffer.

Verification
REQ-026 Write 0x100<=0xAAAA0001 with m_ready=1 -> no stall; next cycle m_req=1, m_we=1, m_addr=0x100, m_wdata=0xAAAA0001; FIFO empty after.
REQ-027 Five back-to-back writes, DEPTH=4, m_ready=0 -> first four accepted, fifth sees c_stall=1 until one pop; memory order 1..5 preserved.
REQ-028 Two writes buffered, then c_rd addr 0x200 with m_rdata=0x12345678 -> both writes drain first, then read issued; c_rdata=0x12345678 in RESP, c_stall low exactly one cycle.
REQ-029 m_ready held 0 for 3 cycles during DRAIN -> m_addr/m_wdata stable all 3 cycles; pop only on ready cycle.
REQ-030 reset asserted in READ state -> next cycle m_req=0, count=0, c_stall=0, c_rdata=0.
REQ-031 Full FIFO, push and pop in same cycle -> push rejected, count 3 after edge, pointer wrap verified after 9 total writes.
